// File: rtl/shallow_fifo_stream_reader.sv
// shallow_fifo_stream_reader
// Drains a shallow synchronous FIFO through its combinational-read head port
// and presents the words on a registered valid/ready stream. A two-entry
// output buffer keeps full throughput while keeping m_ready out of the
// fifo_rd_en path: the pop strobe depends only on registered occupancy and
// the FIFO flags.
module shallow_fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            buf_count,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    // Buffer occupancy doubles as the control state.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t                  occ_r;
    occ_t                  occ_next_s;
    logic [DATA_WIDTH-1:0] slot0_r;
    logic [DATA_WIDTH-1:0] slot1_r;
    logic [DATA_WIDTH-1:0] slot0_next_s;
    logic [DATA_WIDTH-1:0] slot1_next_s;
    logic                  valid_r;
    logic                  valid_next_s;
    logic [CNT_WIDTH-1:0]  xfer_r;
    logic                  push_s;
    logic                  pop_s;

    // A beat leaves when the registered valid meets the consumer's ready.
    assign pop_s = valid_r & m_ready;

    // Pop the FIFO only when room is guaranteed from registered occupancy
    // alone; rst and flush both suppress the strobe.
    assign push_s = ~rst & ~flush & ~fifo_empty & (occ_r != OCC_TWO);

    assign fifo_rd_en = push_s;
    assign m_valid    = valid_r;
    assign m_data     = slot0_r;
    assign buf_count  = occ_r;
    assign xfer_count = xfer_r;

    // Next-state and slot update rules; slot0 is always the head word.
    always_comb begin
        occ_next_s   = occ_r;
        slot0_next_s = slot0_r;
        slot1_next_s = slot1_r;
        if (flush) begin
            // Buffered words are discarded; slot contents become don't-care.
            occ_next_s = OCC_EMPTY;
        end else begin
            case (occ_r)
                OCC_EMPTY: begin
                    if (push_s) begin
                        slot0_next_s = fifo_rd_data;
                        occ_next_s   = OCC_ONE;
                    end else begin
                        occ_next_s = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (push_s && pop_s) begin
                        // Head leaves and the new word takes its place.
                        slot0_next_s = fifo_rd_data;
                        occ_next_s   = OCC_ONE;
                    end else if (push_s) begin
                        slot1_next_s = fifo_rd_data;
                        occ_next_s   = OCC_TWO;
                    end else if (pop_s) begin
                        occ_next_s = OCC_EMPTY;
                    end else begin
                        occ_next_s = OCC_ONE;
                    end
                end
                OCC_TWO: begin
                    // push_s is structurally 0 here.
                    if (pop_s) begin
                        slot0_next_s = slot1_r;
                        occ_next_s   = OCC_ONE;
                    end else begin
                        occ_next_s = OCC_TWO;
                    end
                end
                default: begin
                    occ_next_s = OCC_EMPTY;
                end
            endcase
        end
        valid_next_s = (occ_next_s != OCC_EMPTY);
    end

    // Occupancy, valid flag and slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r   <= OCC_EMPTY;
            valid_r <= 1'b0;
            slot0_r <= {DATA_WIDTH{1'b0}};
            slot1_r <= {DATA_WIDTH{1'b0}};
        end else begin
            occ_r   <= occ_next_s;
            valid_r <= valid_next_s;
            slot0_r <= slot0_next_s;
            slot1_r <= slot1_next_s;
        end
    end

    // Completed-transfer counter; flush does not cancel a pop in its cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_r <= {CNT_WIDTH{1'b0}};
        end else if (pop_s) begin
            xfer_r <= xfer_r + CNT_WIDTH'(1);
        end else begin
            xfer_r <= xfer_r;
        end
    end

endmodule

// File: tb/tb_shallow_fifo_stream_reader.sv
// Self-checking bench for shallow_fifo_stream_reader. A queue stands in for
// the FIFO, and the output buffer is modelled as a queue of at most two words.
module tb_shallow_fifo_stream_reader;

    localparam int DW    = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             fifo_rd_en;
    logic [DW-1:0]    fifo_rd_data;
    logic             fifo_empty;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic [1:0]       buf_count;
    logic [CNT_W-1:0] xfer_count;

    bit [DW-1:0] fifo_q[$];
    bit [DW-1:0] buf_q[$];
    int          exp_xfer;
    int          passed;
    int          total;

    shallow_fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .buf_count    (buf_count),
        .xfer_count   (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Present the FIFO head from the model queue.
    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        if (fifo_q.size() != 0) fifo_rd_data = fifo_q[0];
        else fifo_rd_data = DW'($urandom);
    endtask

    // One clock cycle: called just after a negedge, returns at the next one.
    task automatic step(input bit rdy, input bit fl);
        bit exp_push;
        bit exp_valid;
        m_ready = rdy;
        flush   = fl;
        drive_fifo();
        #1;
        exp_push  = !fl && (fifo_q.size() != 0) && (buf_q.size() < 2);
        exp_valid = (buf_q.size() != 0);
        check_val("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_push));
        check_val("m_valid",    32'(m_valid),    32'(exp_valid));
        check_val("buf_count",  32'(buf_count),  32'(buf_q.size()));
        check_val("xfer_count", 32'(xfer_count), 32'(exp_xfer % (1 << CNT_W)));
        if (exp_valid) check_val("m_data", 32'(m_data), 32'(buf_q[0]));
        // Model update for the coming edge.
        if (exp_valid && rdy) begin
            void'(buf_q.pop_front());
            exp_xfer++;
        end
        if (fl) buf_q.delete();
        else if (exp_push) buf_q.push_back(fifo_q.pop_front());
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        check_val({tag, "_valid"}, 32'(m_valid),    32'd0);
        check_val({tag, "_data"},  32'(m_data),     32'd0);
        check_val({tag, "_count"}, 32'(buf_count),  32'd0);
        check_val({tag, "_xfer"},  32'(xfer_count), 32'd0);
    endtask

    // Reset with a non-empty FIFO head to prove rd_en stays low.
    task automatic do_reset();
        rst          = 1'b1;
        fifo_empty   = 1'b0;
        fifo_rd_data = DW'($urandom);
        m_ready      = 1'b1;
        flush        = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_reset_outputs("rst");
        end
        fifo_q.delete();
        buf_q.delete();
        exp_xfer = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (fifo_q.size() == 0 && buf_q.size() == 0) break;
            step(1'b1, 1'b0);
        end
        check_val("drained", 32'(buf_q.size() + fifo_q.size()), 32'd0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        exp_xfer = 0;
        rst = 1'b1;
        flush = 1'b0;
        m_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_rd_data = '0;
        #2;
        do_reset();

        // Single word.
        fifo_q.push_back(8'hA5);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_val("single_xfer", 32'(xfer_count), 32'd1);

        // Streaming 0x00..0x1F; 32 beats wrap the 4-bit counter twice.
        do_reset();
        for (int i = 0; i < 32; i++) fifo_q.push_back(DW'(i));
        drain(40);
        step(1'b1, 1'b0);
        check_val("stream_buf", 32'(buf_count), 32'd0);

        // Backpressure mid-stream.
        do_reset();
        for (int i = 0; i < 20; i++) fifo_q.push_back(DW'(8'h40 + i));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        check_val("bp_full", 32'(buf_count), 32'd2);
        drain(30);

        // Flush at occupancy 2.
        do_reset();
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        fifo_q.push_back(8'h33);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_val("flush_next", 32'(xfer_count), 32'd1);

        // Asynchronous reset between edges at occupancy 2 with a busy FIFO.
        do_reset();
        for (int i = 0; i < 5; i++) fifo_q.push_back(DW'(8'h70 + i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        do_reset();

        // Counter wrap: 17 words through a 4-bit counter.
        for (int i = 0; i < 17; i++) fifo_q.push_back(DW'($urandom));
        drain(25);
        check_val("wrap", 32'(xfer_count), 32'd1);

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 3000; i++) begin
            if (fifo_q.size() < 8 && $urandom_range(0, 2) != 0)
                fifo_q.push_back(DW'($urandom));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
        end
        drain(30);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
